// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder and its TX FIFO.
package spi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] IDLE_FILL = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } spi_state_e;

endpackage

// File: rtl/spi_tx_fifo.sv
// Register-based TX byte FIFO; popping while empty returns the idle fill byte and
// raises a one-cycle underflow pulse.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [BYTE_W-1:0]      din,
  output logic [BYTE_W-1:0]      dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign do_pop    = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push   = push & (~full | do_pop);
  assign underflow = pop & empty;
  assign dout      = empty ? IDLE_FILL : mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_slave_tx_rx.sv
// Mode-0 SPI responder: oversamples mclk/cs/mosi in the clk domain, shifts out bytes
// from the TX FIFO MSB first and strobes each completed received byte.
module spi_slave_tx_rx
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  input  logic                   write,
  input  logic [BYTE_W-1:0]      data,
  output logic [BYTE_W-1:0]      out,
  output logic                   out_valid,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   tx_full,
  output logic                   busy,
  output logic                   tx_overflow,
  output logic                   tx_underrun,
  input  logic                   clr_flags
);

  logic [SYNC_STAGES-1:0] mclk_sync_q, mclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mclk_prev_q, cs_prev_q;
  logic                   mclk_s, cs_s, mosi_s;
  logic                   mclk_rise, mclk_fall, cs_fall;

  spi_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              miso_q, miso_d;
  logic              ovf_q, ovf_d;
  logic              unr_q, unr_d;

  logic              fifo_pop, fifo_full, fifo_empty, fifo_underflow;
  logic [BYTE_W-1:0] fifo_dout;

  spi_tx_fifo #(
    .DEPTH(DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (write),
    .pop      (fifo_pop),
    .din      (data),
    .dout     (fifo_dout),
    .count    (tx_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .underflow(fifo_underflow)
  );

  assign mclk_sync_d = {mclk_sync_q[SYNC_STAGES-2:0], mclk};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  assign mclk_s      = mclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign mclk_rise   = mclk_s & ~mclk_prev_q;
  assign mclk_fall   = ~mclk_s & mclk_prev_q;
  assign cs_fall     = ~cs_s & cs_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    fifo_pop    = 1'b0;
    if (cs_s) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      tx_shift_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) state_d = StLoad;
        end
        StLoad: begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          state_d    = StShift;
        end
        StShift: begin
          if (mclk_rise) begin
            rx_shift_d = {rx_shift_q[BYTE_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              out_d       = {rx_shift_q[BYTE_W-2:0], mosi_s};
              out_valid_d = 1'b1;
            end
          end else if (mclk_fall) begin
            // The falling edge after a full byte fetches the next one, even at frame end.
            if (bit_cnt_q == 4'd8) begin
              fifo_pop   = 1'b1;
              tx_shift_d = fifo_dout;
              bit_cnt_d  = '0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    miso_d = (state_d == StShift) ? tx_shift_d[BYTE_W-1] : 1'b0;
    // A set event in the same cycle as clr_flags keeps the flag raised.
    ovf_d  = (write & fifo_full & ~fifo_pop) ? 1'b1 : (clr_flags ? 1'b0 : ovf_q);
    unr_d  = fifo_underflow ? 1'b1 : (clr_flags ? 1'b0 : unr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      mclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      miso_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      mclk_sync_q <= mclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      mclk_prev_q <= mclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      miso_q      <= miso_d;
      ovf_q       <= ovf_d;
      unr_q       <= unr_d;
    end
  end

  assign miso        = miso_q;
  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign tx_full     = fifo_full;
  assign busy        = ~cs_s;
  assign tx_overflow = ovf_q;
  assign tx_underrun = unr_q;

endmodule

// File: tb/tb_spi_slave_tx_rx.sv
// Self-checking bench: a queue-based SPI/FIFO reference model predicts miso bits,
// received bytes, occupancy and sticky flags for directed and random frames.
module tb_spi_slave_tx_rx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, mclk, cs, mosi, write, clr_flags;
  logic [7:0]    data;
  logic          miso, out_valid, tx_full, busy, tx_overflow, tx_underrun;
  logic [7:0]    out;
  logic [CW-1:0] tx_count;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] model_fifo[$];
  logic       model_ovf, model_unr;
  logic [7:0] frame_mosi[$];
  logic [7:0] got_rx[$];

  spi_slave_tx_rx #(
    .DEPTH      (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mclk       (mclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso),
    .write      (write),
    .data       (data),
    .out        (out),
    .out_valid  (out_valid),
    .tx_count   (tx_count),
    .tx_full    (tx_full),
    .busy       (busy),
    .tx_overflow(tx_overflow),
    .tx_underrun(tx_underrun),
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) got_rx.push_back(out);

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running required=finished");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    write = 1'b1;
    data  = b;
    tick(1);
    write = 1'b0;
    if (model_fifo.size() == DEPTH) model_ovf = 1'b1;
    else model_fifo.push_back(b);
  endtask

  task automatic model_pop(output logic [7:0] v);
    if (model_fifo.size() == 0) begin
      v         = 8'h00;
      model_unr = 1'b1;
    end else begin
      v = model_fifo.pop_front();
    end
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    model_ovf = 1'b0;
    model_unr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_miso"}, 64'(miso), 64'd0);
    check_val({tag, "_out"}, 64'(out), 64'd0);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_tx_count"}, 64'(tx_count), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_ovf"}, 64'(tx_overflow), 64'd0);
    check_val({tag, "_unr"}, 64'(tx_underrun), 64'd0);
  endtask

  // Master side of one frame: nbits mclk cycles (period 8 clk), mosi from frame_mosi.
  task automatic run_frame(input int nbits, input bit do_rst);
    logic [7:0]  cur, tmp;
    logic [63:0] gb, eb;
    logic [7:0]  exp_rx[$];
    gb = '0;
    eb = '0;
    got_rx.delete();
    cs = 1'b0;
    model_pop(cur);
    tick(8);
    for (int b = 0; b < nbits; b++) begin
      tmp  = frame_mosi[b / 8];
      mosi = tmp[7 - (b % 8)];
      tick(2);
      gb[63 - b] = miso;
      eb[63 - b] = cur[7 - (b % 8)];
      mclk = 1'b1;
      tick(4);
      mclk = 1'b0;
      if (b % 8 == 7) begin
        exp_rx.push_back(tmp);
        model_pop(cur);
      end
      tick(2);
    end
    if (do_rst) begin
      rst = 1'b1;
      cs  = 1'b1;
      tick(2);
      check_reset_state("midrst");
      rst = 1'b0;
      model_fifo.delete();
      model_ovf = 1'b0;
      model_unr = 1'b0;
      exp_rx.delete();
      tick(2);
    end else begin
      tick(4);
      cs = 1'b1;
      tick(6);
    end
    check_val("miso_bits", gb, eb);
    check_val("rx_count", 64'(got_rx.size()), 64'(exp_rx.size()));
    foreach (exp_rx[i]) begin
      if (i < got_rx.size()) check_val("rx_byte", 64'(got_rx[i]), 64'(exp_rx[i]));
    end
    check_val("miso_idle", 64'(miso), 64'd0);
    check_val("busy_idle", 64'(busy), 64'd0);
    check_val("tx_count", 64'(tx_count), 64'(model_fifo.size()));
    check_val("tx_underrun", 64'(tx_underrun), 64'(model_unr));
    check_val("tx_overflow", 64'(tx_overflow), 64'(model_ovf));
  endtask

  initial begin
    logic [7:0] burst[8];
    int nb;
    burst = '{8'h02, 8'h04, 8'h08, 8'h16, 8'h32, 8'h64, 8'h6F, 8'hFF};
    rst = 1'b1; mclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    write = 1'b0; data = 8'h00; clr_flags = 1'b0;
    model_ovf = 1'b0;
    model_unr = 1'b0;

    tick(2);
    check_reset_state("reset");
    rst = 1'b0;
    tick(2);

    // Single byte
    push_byte(8'hA5);
    check_val("count_one", 64'(tx_count), 64'd1);
    frame_mosi = '{8'h3C};
    run_frame(8, 1'b0);
    check_val("out_3c", 64'(out), 64'h3C);

    // Burst to full, dropped ninth write, 64-bit frame
    clear_flags();
    foreach (burst[i]) push_byte(burst[i]);
    check_val("full_flag", 64'(tx_full), 64'd1);
    check_val("full_count", 64'(tx_count), 64'd8);
    push_byte(8'h11);
    check_val("ovf_set", 64'(tx_overflow), 64'(model_ovf));
    check_val("ovf_count", 64'(tx_count), 64'd8);
    frame_mosi.delete();
    for (int i = 0; i < 8; i++) frame_mosi.push_back(8'($urandom));
    run_frame(64, 1'b0);

    // Underrun from an empty FIFO, then clear
    clear_flags();
    frame_mosi = '{8'hC3};
    run_frame(8, 1'b0);
    check_val("unr_set", 64'(tx_underrun), 64'd1);
    check_val("out_c3", 64'(out), 64'hC3);
    clear_flags();
    check_val("unr_clear", 64'(tx_underrun), 64'd0);

    // Abort after 3 bits, then a fresh frame
    push_byte(8'hF0);
    frame_mosi = '{8'($urandom)};
    run_frame(3, 1'b0);
    push_byte(8'h81);
    frame_mosi = '{8'($urandom)};
    run_frame(8, 1'b0);

    // Reset after 5 bits, then a normal frame
    push_byte(8'h5A);
    frame_mosi = '{8'($urandom)};
    run_frame(5, 1'b1);
    push_byte(8'h96);
    frame_mosi = '{8'($urandom)};
    run_frame(8, 1'b0);

    // Random traffic
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) clear_flags();
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) push_byte(8'($urandom));
      check_val("rnd_count", 64'(tx_count), 64'(model_fifo.size()));
      nb = $urandom_range(1, 3);
      frame_mosi.delete();
      for (int k = 0; k < nb; k++) frame_mosi.push_back(8'($urandom));
      run_frame(nb * 8, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_tx_rx.md
Name: spi_slave_tx_rx

Overview:
- SPI responder (slave) for the far end of the team's SPI master link (ports mclk, cs, mosi, miso).
- Mode 0, MSB first, cs active-low.
- Oversamples the SPI pins in the local `clk` domain.
- Returns bytes preloaded into a small TX FIFO and presents each received byte with a one-cycle valid strobe.

Parameters:
- DEPTH, 8, TX FIFO entries (power of 2, ≥2)
- SYNC_STAGES, 2, synchroniser flops on mclk/cs/mosi (≥2)

Ports:
- clk  in  1  system clock; must be ≥4× mclk frequency
- rst  in  1  synchronous active-high reset
- mclk  in  1  SPI clock from master, idle low
- cs  in  1  chip select, active low
- mosi  in  1  serial data from master
- miso  out  1  serial data to master; driven 0 when cs high
- write  in  1  push `data` into TX FIFO (one entry per high cycle)
- data  in  8  TX byte to push
- out  out  8  last completed received byte
- out_valid  out  1  one-cycle pulse when `out` updates
- tx_count  out  $clog2(DEPTH)+1  FIFO occupancy
- tx_full  out  1  tx_count==DEPTH
- busy  out  1  frame in progress (synced cs low)
- tx_overflow  out  1  sticky: write while full without same-cycle pop
- tx_underrun  out  1  sticky: byte load with FIFO empty
- clr_flags  in  1  clears both sticky flags next cycle

Behaviour:
- Reset (sync, rst=1 at posedge clk): all outputs 0.
  - FIFO emptied, synchronisers cleared, state IDLE, bit counter 0.
  - Reset mid-frame aborts the frame; no out_valid is issued.
- Synchronisation: mclk, cs, mosi each pass through SYNC_STAGES flops; edges of mclk are detected on the synced value (rise/fall = 1-cycle pulses).
- States:
  - IDLE → LOAD on synced cs falling.
  - LOAD (1 cycle): pop FIFO head into tx_shift; if empty, load 8'h00 and set tx_underrun. Then → SHIFT.
  - SHIFT: miso = tx_shift[7].
    - On mclk rise: rx_shift = {rx_shift[6:0], mosi_sync}; bit_cnt++.
    - On mclk fall: if bit_cnt==8, pop the next byte as in LOAD and set bit_cnt=0; else tx_shift <<= 1.
    - On the rise making bit_cnt==8: out <= {rx_shift[6:0], mosi_sync} and out_valid pulses the following cycle, i.e. at most SYNC_STAGES+2 clk after the pin edge.
  - Any state: synced cs high → IDLE. bit_cnt=0, miso=0, partial RX discarded, no out_valid; a popped partial TX byte is lost.
- FIFO behaviour:
  - write while not full: entry appended.
  - write while full with a same-cycle pop: accepted.
  - write while full without a pop: dropped, tx_overflow=1.
  - Simultaneous push+pop with count 0: pop sees empty (underrun), the push is stored.
  - Pointers wrap modulo DEPTH.
- Flags: clr_flags and a same-cycle set event → set wins.
- mclk edges while cs high are ignored. busy = synced cs low.

Decomposition:
- Package spi_pkg:
  - BYTE_W=8.
  - State enum {IDLE, LOAD, SHIFT}.
  - Idle fill byte 8'h00.
- Sub-module spi_tx_fifo: register FIFO with parameter DEPTH; ports push/pop/din/dout/count/full/empty. Pop on empty returns 8'h00 and asserts an `underflow` pulse.
- Synchroniser and shifter logic stay in the top module.

Test Plan:
1. Reset check: assert rst 2 cycles → miso=0, out=0, out_valid=0, tx_count=0, both flags 0.
2. Single byte:
   - Stimulus: push 8'hA5; cs low; 8 mclk cycles (period 8 clk) with mosi carrying 8'h3C MSB first.
   - Response: miso bits 1,0,1,0,0,1,0,1; out=8'h3C with exactly one out_valid; tx_count 1→0.
3. Burst and full:
   - Stimulus: push 02,04,08,16,32,64,6F,FF → tx_full=1, tx_count=8. A 9th write of 8'h11 → dropped, tx_overflow=1. Then one cs-low frame of 64 mclk cycles.
   - Response: miso returns the 8 bytes in order; 8 out_valid pulses; tx_count=0.
4. Underrun: FIFO empty; cs low; 8 mclk with mosi=8'hC3 → miso all 0, tx_underrun=1, out=8'hC3 valid. clr_flags → tx_underrun=0.
5. Abort: push 8'hF0; cs high after 3 mclk rises → no out_valid, miso=0. Next frame with push 8'h81 → miso starts at bit7=1; out matches the new mosi byte.
6. Mid-frame reset: rst asserted after 5 bits → all outputs 0; a subsequent full frame works normally.
